mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 141 ++++++++++++++
 tb/tb_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: services read/write requests from a word array after LATENCY cycles.
// Define MEM_RESP_ERR_EN to flag out-of-range or misaligned addresses with state code 3'b111.
module mem_responder #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] wd,
    output logic [31:0] rdata,
    output logic [2:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    fsm_t              r_fsm;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_wd;
    logic              r_wr;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [DEPTH];

    logic              w_req;
    logic [ADDR_W-1:0] w_idx;
    logic              w_err;
    logic              w_start;
    logic              w_last_busy;
    logic              w_commit;
    logic [ADDR_W-1:0] w_c_idx;
    logic [31:0]       w_c_wd;
    logic              w_c_wr;
    logic              w_c_err;

    assign w_req       = mem_read | mem_write;
    assign w_idx       = addr[ADDR_W+1:2];
    assign w_start     = (r_fsm == S_IDLE) && w_req;
    assign w_last_busy = (r_fsm == S_BUSY) && (r_cnt == '0);
    assign w_commit    = ((LATENCY == 1) && w_start) || w_last_busy;

    // With LATENCY=1 the capture edge is also the commit edge, so the live inputs are the captured ones.
    assign w_c_idx = w_last_busy ? r_idx : w_idx;
    assign w_c_wd  = w_last_busy ? r_wd  : wd;
    assign w_c_wr  = w_last_busy ? r_wr  : mem_write;

`ifdef MEM_RESP_ERR_EN
    logic r_err;

    assign w_err   = (addr[31:ADDR_W+2] != '0) || (addr[1:0] != 2'b00);
    assign w_c_err = w_last_busy ? r_err : w_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= w_err;
        end
    end
`else
    logic w_unused_addr;

    assign w_err         = 1'b0;
    assign w_c_err       = 1'b0;
    assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
`endif

    // Array is deliberately not reset; rst gating discards a commit while reset is held.
    always_ff @(posedge clk) begin
        if (rst && w_commit && w_c_wr && !w_c_err) begin
            r_mem[w_c_idx] <= w_c_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm   <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wd    <= '0;
            r_wr    <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_commit && !w_c_wr && !w_c_err) begin
                r_rdata <= r_mem[w_c_idx];
            end
            case (r_fsm)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx <= w_idx;
                        r_wd  <= wd;
                        r_wr  <= mem_write;
                        if (LATENCY == 1) begin
                            r_fsm <= S_DONE;
                        end else begin
                            r_fsm <= S_BUSY;
                            r_cnt <= CNT_INIT;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_fsm <= S_DONE;
                    end
                end
                S_DONE:  r_fsm <= S_IDLE;
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        state = 3'b000;
        if (rst) begin
            case (r_fsm)
                S_IDLE:  state = w_req ? 3'b001 : 3'b000;
                S_BUSY:  state = 3'b001;
`ifdef MEM_RESP_ERR_EN
                S_DONE:  state = r_err ? 3'b111 : 3'b010;
`else
                S_DONE:  state = 3'b010;
`endif
                default: state = 3'b000;
            endcase
        end
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver queues expected DONE responses, a monitor checks them.
module tb_mem_responder;

    localparam int unsigned LAT = 3;

    typedef struct {
        logic [2:0]  code;
        logic [31:0] rd;
        bit          chk;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [2:0]  state;

    logic        d1_rst;
    logic [31:0] d1_addr;
    logic        d1_rd;
    logic        d1_wr;
    logic [31:0] d1_wd;
    logic [31:0] d1_rdata;
    logic [2:0]  d1_state;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    mem_responder #(.LATENCY(LAT), .DEPTH(256), .ADDR_W(8)) u_dut (
        .clk(clk), .rst(rst), .addr(addr), .mem_read(mem_read), .mem_write(mem_write),
        .wd(wd), .rdata(rdata), .state(state)
    );

    mem_responder #(.LATENCY(1), .DEPTH(256), .ADDR_W(8)) u_dut1 (
        .clk(clk), .rst(d1_rst), .addr(d1_addr), .mem_read(d1_rd), .mem_write(d1_wr),
        .wd(d1_wd), .rdata(d1_rdata), .state(d1_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: counts freeze cycles and pops one expected response per DONE cycle
    initial begin : monitor
        int          fr;
        logic [31:0] hold_rd;
        bit          hold_ok;
        exp_t        e;
        fr = 0;
        hold_rd = '0;
        hold_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                fr = 0;
                hold_rd = '0;
                hold_ok = 1'b1;
            end else if (state == 3'b001) begin
                fr++;
                if (hold_ok) chk("rdata_hold", rdata, hold_rd);
            end else if (state == 3'b010 || state == 3'b111) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got state %b with empty scoreboard at %0t", state, $time);
                end else begin
                    e = q.pop_front();
                    chk("done_code", 32'(state), 32'(e.code));
                    chk("freeze_len", 32'(fr), LAT);
                    if (e.chk) begin
                        chk("done_rdata", rdata, e.rd);
                        hold_rd = e.rd;
                        hold_ok = 1'b1;
                    end else begin
                        hold_ok = 1'b0;
                    end
                end
                fr = 0;
            end else begin
                fr = 0;
            end
        end
    end

    // Called at posedge+1 with the request already driven; returns at posedge+1 after DONE
    task automatic wait_done(input bit perturb);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (perturb && n == 2) begin
                addr = addr ^ 32'h10;
                wd   = ~wd;
            end
        end while (!(state == 3'b010 || state == 3'b111) && n < 50);
        if (n >= 50) begin
            n_chk++;
            $display("FAIL done_timeout: state %b after %0d cycles", state, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input bit c, input bit perturb);
        exp_t e;
        e.code = 3'b010;
        e.rd   = exp_rd;
        e.chk  = c;
        q.push_back(e);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wd        = d;
        wait_done(perturb);
    endtask

    task automatic idle(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        exp_t e;
        rst = 1'b0;      d1_rst = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; addr = 32'h10; wd = '0;
        d1_rd = 1'b0;    d1_wr = 1'b0;     d1_addr = '0;  d1_wd = '0;

        // Reset holds state at 000 even with a request pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'(state), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        e.code = 3'b010; e.rd = '0; e.chk = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b1; d1_rst = 1'b1;
        #1;
        chk("release_freeze", 32'(state), 32'h1);
        wait_done(1'b0);

        idle(1);
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, '0, 1'b0, 1'b0);
        idle(2);
        do_req(1'b1, 1'b0, 32'h10, '0, 32'hDEADBEEF, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, '0, 32'hDEADBEEF, 1'b1, 1'b0);
        idle(1);
        do_req(1'b1, 1'b1, 32'h20, 32'h1234, 32'hDEADBEEF, 1'b1, 1'b0);
        idle(1);
        do_req(1'b1, 1'b0, 32'h20, '0, 32'h1234, 1'b1, 1'b1);
        idle(1);
        do_req(1'b0, 1'b1, 32'h30, 32'h0, 32'h1234, 1'b1, 1'b0);
        idle(1);

        // Write interrupted by reset in its second BUSY cycle must not land
        mem_write = 1'b1; addr = 32'h30; wd = 32'hCAFEF00D;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        chk("midop_reset_state", 32'(state), 32'h0);
        chk("midop_reset_rdata", rdata, 32'h0);
        mem_write = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        idle(1);
        do_req(1'b1, 1'b0, 32'h30, '0, 32'h0, 1'b1, 1'b0);
        idle(1);

        do_req(1'b0, 1'b1, 32'h400, 32'h5A5A5A5A, 32'h0, 1'b1, 1'b0);
        idle(1);
        do_req(1'b1, 1'b0, 32'h0, '0, 32'h5A5A5A5A, 1'b1, 1'b0);
        do_req(1'b0, 1'b1, 32'h3FC, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 32'h403, '0, 32'h5A5A5A5A, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 32'h3FC, '0, 32'hFFFFFFFF, 1'b1, 1'b0);
        idle(3);
        chk("queue_drained", 32'(q.size()), 32'h0);

        // LATENCY=1 instance: one freeze cycle, then DONE
        d1_wr = 1'b1; d1_addr = 32'h8; d1_wd = 32'h77;
        @(negedge clk);
        chk("l1_wr_freeze", 32'(d1_state), 32'h1);
        @(negedge clk);
        chk("l1_wr_done", 32'(d1_state), 32'h2);
        chk("l1_wr_rdata", d1_rdata, 32'h0);
        @(posedge clk);
        #1;
        d1_wr = 1'b0; d1_rd = 1'b1;
        @(negedge clk);
        chk("l1_rd_freeze", 32'(d1_state), 32'h1);
        @(negedge clk);
        chk("l1_rd_done", 32'(d1_state), 32'h2);
        chk("l1_rd_rdata", d1_rdata, 32'h77);
        @(posedge clk);
        #1;
        d1_rd = 1'b0;
        @(negedge clk);
        chk("l1_idle", 32'(d1_state), 32'h0);
        chk("l1_rdata_hold", d1_rdata, 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
